// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage and its IF/ID register.
package if_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } if_state_e;

  // Instruction addresses are word aligned; low bits of any target are dropped.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & ~32'd3;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds {instruction, PC} for ID, with enable and flush-to-NOP.
module if_id_reg
  import if_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_flush,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc
);

  logic [63:0] r_ifid;

  // A flush only takes effect when the stage is allowed to advance.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ifid <= {NOP_INSTR, 32'd0};
    end else if (i_en) begin
      if (i_flush) begin
        r_ifid <= {NOP_INSTR, 32'd0};
      end else begin
        r_ifid <= {i_instr, i_pc};
      end
    end
  end

  assign o_instr = r_ifid[63:32];
  assign o_pc    = r_ifid[31:0];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, talks to instruction memory over req/ready,
// and feeds ID through the IF/ID register, honouring stalls and redirects.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] P_RESET_PC = RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id
);

  if_state_e   r_state;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_buf_instr;
  logic [31:0] r_buf_pc;
  logic        r_req;

  logic        w_redirect;
  logic        w_accept;
  logic [31:0] w_jump_pc;
  logic [31:0] w_pc_inc;
  logic        w_have;
  logic [31:0] w_id_instr;
  logic [31:0] w_id_pc;
  logic        w_id_flush;

  // Branch/Jump from a stalled ID are ignored; ID re-evaluates them next cycle.
  assign w_redirect = (Branch | Jump) & IFWrite;
  assign w_accept   = imem_ready & r_req;
  assign w_jump_pc  = align_pc(JumpAddr);
  assign w_pc_inc   = r_pc + 32'd4;

  // An instruction is available to ID from a fresh response or from the hold buffer.
  always_comb begin
    w_have     = 1'b0;
    w_id_instr = imem_rdata;
    w_id_pc    = r_pc;
    case (r_state)
      FETCH: begin
        w_have = w_accept;
      end
      HOLD: begin
        w_have     = 1'b1;
        w_id_instr = r_buf_instr;
        w_id_pc    = r_buf_pc;
      end
      default: begin
        w_have = 1'b0;
      end
    endcase
  end

  assign w_id_flush = ~w_have | w_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= FETCH;
      r_pc        <= P_RESET_PC;
      r_tgt       <= 32'd0;
      r_buf_instr <= 32'd0;
      r_buf_pc    <= 32'd0;
      r_req       <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          r_req <= 1'b1;
          if (w_accept) begin
            if (w_redirect) begin
              r_pc <= w_jump_pc;
            end else if (IFWrite) begin
              r_pc <= w_pc_inc;
            end else begin
              r_buf_instr <= imem_rdata;
              r_buf_pc    <= r_pc;
              r_state     <= HOLD;
              r_req       <= 1'b0;
            end
          end else if (w_redirect) begin
            r_tgt   <= w_jump_pc;
            r_state <= DISCARD;
          end
        end
        HOLD: begin
          if (w_redirect) begin
            r_pc    <= w_jump_pc;
            r_state <= FETCH;
            r_req   <= 1'b1;
          end else if (IFWrite) begin
            r_pc    <= w_pc_inc;
            r_state <= FETCH;
            r_req   <= 1'b1;
          end
        end
        DISCARD: begin
          // The outstanding request must complete at its original address before retargeting.
          if (w_accept) begin
            r_pc    <= w_redirect ? w_jump_pc : r_tgt;
            r_state <= FETCH;
          end else if (w_redirect) begin
            r_tgt <= w_jump_pc;
          end
        end
        default: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
      endcase
    end
  end

  assign imem_req  = r_req;
  assign imem_addr = r_pc;

  if_id_reg u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .i_en    (IFWrite),
    .i_flush (w_id_flush),
    .i_instr (w_id_instr),
    .i_pc    (w_id_pc),
    .o_instr (Instruction_id),
    .o_pc    (PC_id)
  );

endmodule
